// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: raises INT, walks the two-pulse INTA handshake,
// sets/clears ISR bits and drives the vector byte during the second pulse.
module inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT_request,
  input  logic [2:0] serviced_interrupt_index,
  input  logic       INTA_n,
  input  logic [4:0] vector_base,
  input  logic       AEOI,
  output logic       INT,
  output logic       INT_requestAck,
  output logic       freezing,
  output logic       ISR_set,
  output logic [2:0] ISR_set_index,
  output logic       ISR_clear,
  output logic [2:0] ISR_clear_index,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    ACK1    = 3'd2,
    GAP     = 3'd3,
    ACK2    = 3'd4
  } state_t;

  state_t     r_state, w_next_state;
  logic       r_sync1, r_sync2, r_sync3;
  logic       r_int, r_ack, r_freezing, r_isr_set, r_isr_clear, r_data_en, r_spurious;
  logic [2:0] r_isr_set_idx, r_isr_clear_idx, r_latched_idx;
  logic [7:0] r_data_out;

  logic       w_int, w_ack, w_freezing, w_isr_set, w_isr_clear, w_data_en, w_spurious;
  logic [2:0] w_isr_set_idx, w_isr_clear_idx, w_latched_idx;
  logic [7:0] w_data_out;
  logic       w_inta_fall, w_inta_rise;

  // Third sync stage only remembers the previous value of stage 2 for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= INTA_n;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_inta_fall = r_sync3 & ~r_sync2;
  assign w_inta_rise = ~r_sync3 & r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_int           <= 1'b0;
      r_ack           <= 1'b0;
      r_freezing      <= 1'b0;
      r_isr_set       <= 1'b0;
      r_isr_set_idx   <= 3'd0;
      r_isr_clear     <= 1'b0;
      r_isr_clear_idx <= 3'd0;
      r_latched_idx   <= 3'd0;
      r_data_out      <= 8'h00;
      r_data_en       <= 1'b0;
      r_spurious      <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_int           <= w_int;
      r_ack           <= w_ack;
      r_freezing      <= w_freezing;
      r_isr_set       <= w_isr_set;
      r_isr_set_idx   <= w_isr_set_idx;
      r_isr_clear     <= w_isr_clear;
      r_isr_clear_idx <= w_isr_clear_idx;
      r_latched_idx   <= w_latched_idx;
      r_data_out      <= w_data_out;
      r_data_en       <= w_data_en;
      r_spurious      <= w_spurious;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_int           = r_int;
    w_ack           = r_ack;
    w_freezing      = r_freezing;
    w_isr_set       = 1'b0;
    w_isr_set_idx   = r_isr_set_idx;
    w_isr_clear     = 1'b0;
    w_isr_clear_idx = r_isr_clear_idx;
    w_latched_idx   = r_latched_idx;
    w_data_out      = r_data_out;
    w_data_en       = r_data_en;
    w_spurious      = r_spurious;

    unique case (r_state)
      IDLE: begin
        if (INT_request) begin
          w_next_state = PENDING;
          w_int        = 1'b1;
          w_ack        = ~r_ack;
        end
      end
      PENDING: begin
        if (w_inta_fall) begin
          w_next_state = ACK1;
          w_int        = 1'b0;
          w_freezing   = 1'b1;
          // A request withdrawn before the first INTA becomes a spurious IR7 vector.
          if (INT_request) begin
            w_latched_idx = serviced_interrupt_index;
            w_isr_set     = 1'b1;
            w_isr_set_idx = serviced_interrupt_index;
            w_spurious    = 1'b0;
          end else begin
            w_latched_idx = 3'd7;
            w_spurious    = 1'b1;
          end
        end
      end
      ACK1: begin
        if (w_inta_rise) begin
          w_next_state = GAP;
        end
      end
      GAP: begin
        if (w_inta_fall) begin
          w_next_state = ACK2;
          w_data_out   = {vector_base, r_latched_idx};
          w_data_en    = 1'b1;
        end
      end
      ACK2: begin
        if (w_inta_rise) begin
          w_next_state = IDLE;
          w_data_out   = 8'h00;
          w_data_en    = 1'b0;
          w_freezing   = 1'b0;
          if (AEOI && !r_spurious) begin
            w_isr_clear     = 1'b1;
            w_isr_clear_idx = r_latched_idx;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign INT             = r_int;
  assign INT_requestAck  = r_ack;
  assign freezing        = r_freezing;
  assign ISR_set         = r_isr_set;
  assign ISR_set_index   = r_isr_set_idx;
  assign ISR_clear       = r_isr_clear;
  assign ISR_clear_index = r_isr_clear_idx;
  assign data_out        = r_data_out;
  assign data_out_en     = r_data_en;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus pushes expected ack/set/vector/clear
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_inta_sequencer;

  logic       clk;
  logic       rst_n;
  logic       INT_request;
  logic [2:0] serviced_interrupt_index;
  logic       INTA_n;
  logic [4:0] vector_base;
  logic       AEOI;
  logic       INT;
  logic       INT_requestAck;
  logic       freezing;
  logic       ISR_set;
  logic [2:0] ISR_set_index;
  logic       ISR_clear;
  logic [2:0] ISR_clear_index;
  logic [7:0] data_out;
  logic       data_out_en;

  localparam int EV_ACK = 0;
  localparam int EV_SET = 1;
  localparam int EV_VEC = 2;
  localparam int EV_CLR = 3;

  typedef struct {
    int         kind;
    logic [7:0] value;
  } event_t;

  event_t sbQ[$];
  int     checkCount = 0;
  int     errCount   = 0;
  logic   tbAck      = 1'b0;
  logic   prevAck    = 1'b0;
  logic   prevEn     = 1'b0;

  inta_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .INT_request              (INT_request),
    .serviced_interrupt_index (serviced_interrupt_index),
    .INTA_n                   (INTA_n),
    .vector_base              (vector_base),
    .AEOI                     (AEOI),
    .INT                      (INT),
    .INT_requestAck           (INT_requestAck),
    .freezing                 (freezing),
    .ISR_set                  (ISR_set),
    .ISR_set_index            (ISR_set_index),
    .ISR_clear                (ISR_clear),
    .ISR_clear_index          (ISR_clear_index),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushEvent(input int kind, input logic [7:0] value);
    event_t ev;
    ev.kind  = kind;
    ev.value = value;
    sbQ.push_back(ev);
  endtask

  task automatic pushAck();
    tbAck = ~tbAck;
    pushEvent(EV_ACK, {7'd0, tbAck});
  endtask

  task automatic scoreEvent(input int kind, input logic [7:0] value);
    event_t ev;
    checkCount++;
    if (sbQ.size() == 0) begin
      errCount++;
      $display("[TB] FAIL unexpected_event kind=%0d actual=%h required=none at %0t", kind, value, $time);
    end else begin
      ev = sbQ.pop_front();
      if (ev.kind != kind || ev.value !== value) begin
        errCount++;
        $display("[TB] FAIL event_order actual kind=%0d val=%h required kind=%0d val=%h at %0t",
                 kind, value, ev.kind, ev.value, $time);
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives INTA_n to a level and holds it for the given number of clock cycles.
  task automatic applyStimulus(input logic intaLevel, input int cycles);
    INTA_n = intaLevel;
    waitCycles(cycles);
  endtask

  // Outside reset every observable DUT event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevAck = INT_requestAck;
      prevEn  = data_out_en;
    end else begin
      if (INT_requestAck !== prevAck) scoreEvent(EV_ACK, {7'd0, INT_requestAck});
      if (ISR_set) scoreEvent(EV_SET, {5'd0, ISR_set_index});
      if (data_out_en && !prevEn) scoreEvent(EV_VEC, data_out);
      if (ISR_clear) scoreEvent(EV_CLR, {5'd0, ISR_clear_index});
      if (!data_out_en) checkOutput("data_zero_when_disabled", data_out, 8'h00);
      prevAck = INT_requestAck;
      prevEn  = data_out_en;
    end
  end

  initial begin
    rst_n                    = 1'b0;
    INTA_n                   = 1'b1;
    INT_request              = 1'b0;
    serviced_interrupt_index = 3'd0;
    vector_base              = 5'd0;
    AEOI                     = 1'b0;
    #12;
    checkOutput("reset_int", INT, 0);
    checkOutput("reset_ack", INT_requestAck, 0);
    checkOutput("reset_freezing", freezing, 0);
    checkOutput("reset_isr_set", ISR_set, 0);
    checkOutput("reset_isr_clear", ISR_clear, 0);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_data_en", data_out_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitCycles(2);
    $display("[TB] normal sequence");
    vector_base = 5'b01000;
    AEOI = 1'b0;
    serviced_interrupt_index = 3'd3;
    INT_request = 1'b1;
    pushAck();
    pushEvent(EV_SET, 8'h03);
    pushEvent(EV_VEC, 8'h43);
    waitCycles(3);
    checkOutput("normal_int_raised", INT, 1);
    applyStimulus(1'b0, 4);
    checkOutput("normal_freezing_ack1", freezing, 1);
    checkOutput("normal_int_dropped", INT, 0);
    INT_request = 1'b0;
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("normal_vector", data_out, 8'h43);
    checkOutput("normal_vector_en", data_out_en, 1);
    applyStimulus(1'b1, 4);
    checkOutput("normal_freezing_end", freezing, 0);
    checkOutput("normal_en_end", data_out_en, 0);
    $display("[TB] AEOI sequence");
    AEOI = 1'b1;
    INT_request = 1'b1;
    pushAck();
    pushEvent(EV_SET, 8'h03);
    pushEvent(EV_VEC, 8'h43);
    pushEvent(EV_CLR, 8'h03);
    waitCycles(3);
    applyStimulus(1'b0, 4);
    INT_request = 1'b0;
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("aeoi_vector", data_out, 8'h43);
    applyStimulus(1'b1, 4);
    checkOutput("aeoi_freezing_end", freezing, 0);
    $display("[TB] spurious sequence");
    serviced_interrupt_index = 3'd5;
    INT_request = 1'b1;
    pushAck();
    pushEvent(EV_VEC, 8'h47);
    waitCycles(3);
    INT_request = 1'b0;
    waitCycles(2);
    applyStimulus(1'b0, 4);
    checkOutput("spurious_freezing", freezing, 1);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("spurious_vector", data_out, 8'h47);
    applyStimulus(1'b1, 4);
    checkOutput("spurious_freezing_end", freezing, 0);
    $display("[TB] back-to-back sequences");
    AEOI = 1'b0;
    serviced_interrupt_index = 3'd6;
    INT_request = 1'b1;
    pushAck();
    pushEvent(EV_SET, 8'h06);
    pushEvent(EV_VEC, 8'h46);
    pushAck();
    pushEvent(EV_SET, 8'h01);
    pushEvent(EV_VEC, 8'h41);
    waitCycles(3);
    applyStimulus(1'b0, 4);
    serviced_interrupt_index = 3'd1;
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("b2b_first_vector", data_out, 8'h46);
    applyStimulus(1'b1, 4);
    checkOutput("b2b_int_reraised", INT, 1);
    applyStimulus(1'b0, 4);
    INT_request = 1'b0;
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("b2b_second_vector", data_out, 8'h41);
    applyStimulus(1'b1, 4);
    checkOutput("b2b_ack_level", INT_requestAck, tbAck);
    $display("[TB] reset during GAP");
    AEOI = 1'b1;
    serviced_interrupt_index = 3'd2;
    INT_request = 1'b1;
    pushAck();
    pushEvent(EV_SET, 8'h02);
    waitCycles(3);
    applyStimulus(1'b0, 4);
    INT_request = 1'b0;
    applyStimulus(1'b1, 4);
    #2 rst_n = 1'b0;
    #1;
    tbAck = 1'b0;
    checkOutput("rst_gap_int", INT, 0);
    checkOutput("rst_gap_ack", INT_requestAck, 0);
    checkOutput("rst_gap_freezing", freezing, 0);
    checkOutput("rst_gap_set_index", ISR_set_index, 0);
    checkOutput("rst_gap_data_en", data_out_en, 0);
    waitCycles(2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 4);
    checkOutput("rst_gap_post_freezing", freezing, 0);
    checkOutput("rst_gap_post_en", data_out_en, 0);
    $display("[TB] stray INTA in IDLE");
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 4);
    checkOutput("stray_int", INT, 0);
    checkOutput("stray_freezing", freezing, 0);
    checkOutput("stray_data_en", data_out_en, 0);
    checkOutput("stray_ack", INT_requestAck, tbAck);
    waitCycles(5);
    checkOutput("scoreboard_drained", 8'(sbQ.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have clk, input, 1: single system clock; all state on rising edge.
REQ-002 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have INT_request, input, 1: level request from priority resolver.
REQ-004 SHALL have serviced_interrupt_index, input, 3: highest-priority pending IR from resolver.
REQ-005 SHALL have INTA_n, input, 1: CPU interrupt-acknowledge strobe, asynchronous, active-low.
REQ-006 SHALL have vector_base, input, 5: ICW2 bits T7..T3.
REQ-007 SHALL have AEOI, input, 1: automatic end-of-interrupt mode enable.
REQ-008 SHALL have INT, output, 1: interrupt line to CPU.
REQ-009 SHALL have INT_requestAck, output, 1: toggle-acknowledge back to resolver.
REQ-010 SHALL have freezing, output, 1: holds IRR/resolver stable during INTA sequence.
REQ-011 SHALL have ISR_set, output, 1 and ISR_set_index, output, 3: one-cycle set strobe plus bit index.
REQ-012 SHALL have ISR_clear, output, 1 and ISR_clear_index, output, 3: one-cycle AEOI clear strobe plus bit index.
REQ-013 SHALL have data_out, output, 8 and data_out_en, output, 1: vector byte and bus-drive enable.

Function
REQ-014 SHALL synchronise INTA_n with two flip-flops; an edge is detected when sync stage 2 differs from its previous-cycle value.
REQ-015 SHALL act on an INTA_n edge on the 3rd rising clk edge after the pin transition.
REQ-016 SHALL implement states IDLE, PENDING, ACK1, GAP, ACK2.
REQ-017 IDLE: INT_request sampled 1 -> PENDING; INT=1 and INT_requestAck toggles in the same edge.
REQ-018 IDLE: INTA_n edges SHALL be ignored, with no output change.
REQ-019 PENDING: INTA_n falling edge -> ACK1; INT=0, freezing=1, latched_index set in the same edge.
REQ-020 On PENDING->ACK1, if INT_request=1 then latched_index=serviced_interrupt_index and ISR_set pulses for 1 cycle with ISR_set_index=latched_index.
REQ-021 On PENDING->ACK1, if INT_request=0 (request withdrawn) then latched_index=7, ISR_set stays 0, and a spurious flag is set.
REQ-022 ACK1: INTA_n rising edge -> GAP.
REQ-023 GAP: INTA_n falling edge -> ACK2; data_out={vector_base, latched_index} and data_out_en=1 in the same edge.
REQ-024 ACK2: data_out and data_out_en SHALL hold until INTA_n rising edge, then data_out_en=0, data_out=0, freezing=0 -> IDLE.
REQ-025 On ACK2 exit, if AEOI=1 and not spurious, ISR_clear SHALL pulse 1 cycle with ISR_clear_index=latched_index.
REQ-026 data_out SHALL be 8'h00 whenever data_out_en=0.
REQ-027 freezing SHALL be 1 exactly from ACK1 entry through ACK2 exit.
REQ-028 INT_request changes during ACK1/GAP/ACK2 SHALL be ignored; a request still high on IDLE return SHALL start a new sequence next edge.
REQ-029 INT_requestAck SHALL toggle exactly once per IDLE->PENDING transition and never otherwise.
REQ-030 vector_base and AEOI SHALL be sampled at the use edge (REQ-023, REQ-025).

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and INT=0, INT_requestAck=0, freezing=0, ISR_set=0, ISR_clear=0, indices=0, data_out=0, data_out_en=0, spurious=0, sync flops=1.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence; no ISR strobe SHALL be emitted on release.
REQ-033 After rst_n deasserts, the first action SHALL occur no earlier than the next rising clk edge.

Verification
REQ-034 Normal: vector_base=5'b01000, AEOI=0, index=3, INT_request=1, two INTA pulses -> INT rises, ISR_set once with index 3, data_out=8'h43 during 2nd pulse, no ISR_clear, freezing low at end.
REQ-035 AEOI: same stimulus with AEOI=1 -> additionally one ISR_clear pulse, index 3, after 2nd INTA rising edge.
REQ-036 Spurious: INT_request drops before 1st INTA -> no ISR_set, no ISR_clear, data_out=8'h47.
REQ-037 Back-to-back: INT_request held high across 2 sequences with index 6 then 1 -> INT_requestAck toggles twice; vectors 8'h46 then 8'h41.
REQ-038 Reset in GAP: rst_n pulsed low -> all outputs 0 at once, IDLE; no ISR_set or ISR_clear after release.
REQ-039 Stray INTA pulse in IDLE with INT_request=0 -> no output change; INTA_n pulse of 1 clk width -> no state advance.
